// File: rtl/div_iterative.sv
// div_iterative: multi-cycle radix-2 restoring divider behind the EX-stage DIV/DIVU
// start/done handshake. One quotient bit is produced per cycle, so an operation takes
// WIDTH iterations plus accept, done and release cycles.
//
// Ports:
//   clock          core clock, all state updates on the rising edge
//   reset          synchronous, active-high reset
//   start          level request from EX, held for the whole DIV/DIVU occupancy
//   flag_unsigned  1 = DIVU, 0 = DIV (two's complement)
//   operand1       dividend (rs), sampled only in the accept cycle
//   operand2       divisor (rt), sampled only in the accept cycle
//   result         {remainder, quotient}, registered (remainder -> HI, quotient -> LO)
//   done           single-cycle completion pulse, registered
//   busy           high in every state except idle
module div_iterative #(
    parameter int unsigned WIDTH = 32
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 start,
    input  logic                 flag_unsigned,
    input  logic [WIDTH-1:0]     operand1,
    input  logic [WIDTH-1:0]     operand2,
    output logic [2*WIDTH-1:0]   result,
    output logic                 done,
    output logic                 busy
);

    localparam int unsigned CntW = $clog2(WIDTH + 1);
    localparam logic [CntW-1:0] LastCnt = CntW'(WIDTH - 1);

    typedef enum logic [1:0] {
        StIdle,
        StBusy,
        StDone,
        StRelease
    } state_e;

    state_e           state_q;
    logic [CntW-1:0]  cnt_q;
    logic [WIDTH-1:0] rem_q;    // partial remainder
    logic [WIDTH-1:0] quo_q;    // dividend bits shift out the top, quotient bits in the bottom
    logic [WIDTH-1:0] div_q;    // divisor magnitude
    logic             q_neg_q;
    logic             r_neg_q;

    logic             sign1;
    logic             sign2;
    logic [WIDTH-1:0] op1_abs;
    logic [WIDTH-1:0] op2_abs;
    logic [WIDTH:0]   partial;
    logic [WIDTH:0]   diff;
    logic [WIDTH-1:0] rem_nxt;
    logic [WIDTH-1:0] quo_nxt;
    logic [WIDTH-1:0] rem_fin;
    logic [WIDTH-1:0] quo_fin;

    // Operand magnitudes; the most-negative value maps onto itself, which is the
    // correct unsigned magnitude.
    always_comb begin
        sign1   = ~flag_unsigned & operand1[WIDTH-1];
        sign2   = ~flag_unsigned & operand2[WIDTH-1];
        op1_abs = sign1 ? -operand1 : operand1;
        op2_abs = sign2 ? -operand2 : operand2;
    end

    // One restoring step. The partial remainder is kept one bit wider so the
    // trial subtraction's borrow lands in the top bit.
    always_comb begin
        partial = {rem_q, quo_q[WIDTH-1]};
        diff    = partial - {1'b0, div_q};
        rem_nxt = diff[WIDTH] ? partial[WIDTH-1:0] : diff[WIDTH-1:0];
        quo_nxt = (quo_q << 1) | WIDTH'(!diff[WIDTH]);
        rem_fin = r_neg_q ? -rem_nxt : rem_nxt;
        quo_fin = q_neg_q ? -quo_nxt : quo_nxt;
    end

    assign busy = (state_q != StIdle);

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            rem_q   <= '0;
            quo_q   <= '0;
            div_q   <= '0;
            q_neg_q <= 1'b0;
            r_neg_q <= 1'b0;
            result  <= '0;
            done    <= 1'b0;
        end else begin
            done <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (start) begin
                        rem_q   <= '0;
                        quo_q   <= op1_abs;
                        div_q   <= op2_abs;
                        q_neg_q <= sign1 ^ sign2;
                        r_neg_q <= sign1;
                        cnt_q   <= '0;
                        state_q <= StBusy;
                    end
                end
                StBusy: begin
                    rem_q <= rem_nxt;
                    quo_q <= quo_nxt;
                    cnt_q <= cnt_q + CntW'(1);
                    // The final step feeds the sign fix-up directly so done can
                    // rise in the very next cycle.
                    if (cnt_q == LastCnt) begin
                        result  <= {rem_fin, quo_fin};
                        done    <= 1'b1;
                        state_q <= StDone;
                    end
                end
                StDone: begin
                    state_q <= StRelease;
                end
                StRelease: begin
                    // EX still shows the finished instruction here; start is ignored.
                    state_q <= StIdle;
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_div_iterative.sv
module tb_div_iterative;

    logic        clock = 1'b0;
    logic        reset;
    logic        start;
    logic        flag_unsigned;
    logic [31:0] operand1;
    logic [31:0] operand2;
    logic [63:0] result;
    logic        done;
    logic        busy;

    int tests = 0;
    int fails = 0;
    int done_pulses = 0;

    div_iterative #(
        .WIDTH(32)
    ) dut (
        .clock         (clock),
        .reset         (reset),
        .start         (start),
        .flag_unsigned (flag_unsigned),
        .operand1      (operand1),
        .operand2      (operand2),
        .result        (result),
        .done          (done),
        .busy          (busy)
    );

    always #5 clock = ~clock;

    always @(negedge clock) begin
        if (done) done_pulses++;
    end

    // Reference: plain integer division with truncation toward zero; divide by zero
    // follows the restoring-divider convention (all-ones magnitude quotient).
    function automatic logic [63:0] model(input logic [31:0] a, input logic [31:0] b,
                                          input logic u);
        longint sa, sb, q, r;
        if (u) begin
            if (b == 32'd0) return {a, 32'hFFFF_FFFF};
            return {a % b, a / b};
        end
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        if (b == 32'd0) begin
            q = (sa < 0) ? 64'sd1 : -64'sd1;
            r = sa;
        end else begin
            q = sa / sb;
            r = sa % sb;
        end
        return {r[31:0], q[31:0]};
    endfunction

    task automatic check(input logic [63:0] obs, input logic [63:0] exp, input string tag);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Called in an idle cycle; that cycle is the accept cycle (cycle 0).
    // Returns in cycle 35, idle again and ready to accept.
    task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic u,
                          input string tag);
        int n;
        logic [63:0] exp;
        exp = model(a, b, u);
        start = 1'b1;
        flag_unsigned = u;
        operand1 = a;
        operand2 = b;
        check({63'd0, busy}, 64'd0, {tag, " idle at accept"});
        n = 0;
        do begin
            tick();
            n++;
            if (n == 1) check({63'd0, busy}, 64'd1, {tag, " busy"});
            if (n == 5) begin
                // Late operand changes must not affect the in-flight operation.
                operand1 = $urandom;
                operand2 = $urandom;
                flag_unsigned = ~u;
            end
        end while (!done && n < 100);
        check(64'(n), 64'd33, {tag, " done latency"});
        check(result, exp, {tag, " result"});
        start = 1'b0;
        tick();
        check({62'd0, done, busy}, 64'd1, {tag, " release cycle"});
        tick();
        check({62'd0, done, busy}, 64'd0, {tag, " back to idle"});
        check(result, exp, {tag, " result held"});
    endtask

    initial begin
        int n;
        int p0;
        logic [31:0] ra;
        logic [31:0] rb;
        logic        ru;

        reset = 1'b1;
        start = 1'b0;
        flag_unsigned = 1'b0;
        operand1 = '0;
        operand2 = '0;
        tick();
        tick();
        check(result, 64'd0, "reset result");
        check({62'd0, done, busy}, 64'd0, "reset done/busy");
        reset = 1'b0;
        tick();

        run_op(32'd100, 32'd7, 1'b1, "divu 100/7");
        run_op(32'hFFFF_FFF9, 32'd2, 1'b0, "div -7/2");
        run_op(32'd7, 32'hFFFF_FFFE, 1'b0, "div 7/-2");
        run_op(32'h8000_0000, 32'hFFFF_FFFF, 1'b0, "div min/-1");
        run_op(32'hFFFF_FFFF, 32'd1, 1'b1, "divu max/1");
        run_op(32'd5, 32'd0, 1'b1, "divu 5/0");
        run_op(32'hFFFF_FFFB, 32'd0, 1'b0, "div -5/0");
        run_op(32'hFFFF_FFF8, 32'd4, 1'b0, "div -8/4");

        // Back-to-back with start held high.
        p0 = done_pulses;
        start = 1'b1;
        flag_unsigned = 1'b1;
        operand1 = 32'd12;
        operand2 = 32'd5;
        n = 0;
        do begin
            tick();
            n++;
        end while (!done && n < 100);
        check(64'(n), 64'd33, "b2b first latency");
        check(result, {32'd2, 32'd2}, "b2b first result");
        tick();
        n++;
        operand1 = 32'd9;
        operand2 = 32'd4;
        check({62'd0, done, busy}, 64'd1, "b2b cycle 34 release");
        tick();
        n++;
        check({62'd0, done, busy}, 64'd0, "b2b cycle 35 idle");
        do begin
            tick();
            n++;
        end while (!done && n < 150);
        check(64'(n), 64'd68, "b2b second latency");
        check(result, {32'd1, 32'd2}, "b2b second result");
        start = 1'b0;
        tick();
        tick();
        tick();
        check(64'(done_pulses - p0), 64'd2, "b2b pulse count");

        // Reset in cycle 10 of an operation abandons it.
        p0 = done_pulses;
        start = 1'b1;
        flag_unsigned = 1'b1;
        operand1 = 32'd1000;
        operand2 = 32'd3;
        for (int i = 0; i < 10; i++) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check(result, 64'd0, "mid-op reset result");
        check({62'd0, done, busy}, 64'd0, "mid-op reset done/busy");
        run_op(32'd77, 32'hFFFF_FFF8, 1'b0, "after reset 77/-8");
        check(64'(done_pulses - p0), 64'd1, "mid-op reset no stray done");

        // Reset beats a simultaneous start.
        reset = 1'b1;
        start = 1'b1;
        tick();
        reset = 1'b0;
        start = 1'b0;
        check({63'd0, busy}, 64'd0, "reset beats start");
        tick();

        for (int k = 0; k < 24; k++) begin
            ra = $urandom;
            rb = (k % 3 == 0) ? 32'($urandom_range(1, 255)) : $urandom;
            if (k % 4 == 1) rb = -rb;
            if (k == 7) rb = 32'd0;
            ru = 1'($urandom_range(0, 1));
            run_op(ra, rb, ru, $sformatf("random %0d", k));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/div_iterative.md
Name: div_iterative

Overview:
- Multi-cycle radix-2 restoring divider. It is the responder behind the execute stage's DIV/DIVU start/done interface.
- Accepts a start request with operands and a signedness flag. Returns {remainder, quotient}, with remainder going to HI and quotient to LO.
- Pulses done once per operation. The execute stage holds its stall until it has seen done.
- Sits inside the EX-stage divider wrapper. It is instantiated once per core.

Parameters:
- WIDTH, 32, operand width. Iteration count equals WIDTH.

Ports:
- clock  input  1  core clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  level request from EX. Held high for the whole DIV/DIVU occupancy of the EX stage.
- flag_unsigned  input  1  1 = DIVU, 0 = DIV (two's complement).
- operand1  input  WIDTH  dividend (rs).
- operand2  input  WIDTH  divisor (rt).
- result  output  2*WIDTH  {remainder, quotient}. Registered.
- done  output  1  single-cycle completion pulse. Registered.
- busy  output  1  high in every state except IDLE.

Behaviour:
- Reset: on any clock edge with reset=1, state=IDLE, result=0, done=0, busy=0, and the iteration counter is 0. This applies mid-operation too: the in-flight operation is abandoned and no done is produced.
- States are IDLE, BUSY, DONE, RELEASE.
- IDLE, start=0: remain in IDLE. result holds its last value.
- IDLE, start=1: latch operand1, operand2 and flag_unsigned, then go to BUSY with cnt=0.
  - Signed mode: latch |operand1| and |operand2|. Record q_neg = sign1 XOR sign2 and r_neg = sign1.
  - Unsigned mode: q_neg = r_neg = 0.
  - Operands are sampled only in this cycle. Later operand changes are ignored.
- BUSY runs one restoring step per cycle:
  - Shift {rem, quo} left by 1 and bring in the next dividend bit.
  - Trial-subtract the divisor from the WIDTH+1-bit partial remainder.
  - If the result is non-negative, keep it and set the quotient bit to 1. Otherwise restore and set it to 0.
  - cnt increments each cycle. After the step with cnt = WIDTH-1, go to DONE.
- DONE entry: result <= {r_neg ? -rem : rem, q_neg ? -quo : quo}, then assert done=1 for exactly this one cycle and go to RELEASE unconditionally.
- RELEASE lasts exactly one cycle. start is ignored here, because EX still presents the finished instruction while its stall drops. Then go to IDLE.
- Latency, with the start-accept cycle counted as cycle 0:
  - done is high in cycle WIDTH+1 (33 for the default).
  - A start held continuously is re-accepted in cycle WIDTH+3, which supports back-to-back DIVs.
- result is stable from the done cycle until the next accept cycle.
- Divide by zero needs no special path; the natural restoring result applies:
  - Unsigned: quotient = all ones, remainder = dividend.
  - Signed: the magnitude result above, then sign-corrected with q_neg/r_neg. q_neg uses divisor sign 0.
- Most-negative / -1 (signed): quotient = 0x80000000 after the wrap of the negation, remainder = 0. No exception is raised.
- Remainder sign follows the dividend. A zero remainder stays 0.
- Simultaneous reset and start: reset wins.

Test Plan:
- Unsigned 100 / 7: start at cycle 0 -> done=1 only in cycle 33, result = {0x00000002, 0x0000000E}, busy low again from cycle 35.
- Signed -7 / 2 (0xFFFFFFF9, 0x00000002) -> result = {0xFFFFFFFF, 0xFFFFFFFD}. Also 7 / -2 -> {0x00000001, 0xFFFFFFFD}.
- Signed 0x80000000 / 0xFFFFFFFF -> result = {0x00000000, 0x80000000}, no hang. Unsigned 0xFFFFFFFF / 1 -> {0, 0xFFFFFFFF}.
- Divide by zero: DIVU 5/0 -> {0x00000005, 0xFFFFFFFF}. DIV -5/0 -> {0xFFFFFFFB, 0x00000001}.
- Hold start high across two DIVU ops (12/5, then operands changed to 9/4 in cycle 34):
  - done at cycle 33 with {2, 2}. Start is ignored in cycle 34, accepted in cycle 35.
  - Second done at cycle 68 with {1, 2}.
  - Exactly two done pulses.
- Assert reset in cycle 10 of an operation -> done never pulses, result=0, busy=0. A start in the following cycle gives a correct result 33 cycles later.
